// File: rtl/snake_ctrl.sv
// snake_ctrl: game controller feeding snake_field.
// Turns debounced buttons into a start/pause/restart FSM, emits a periodic
// step pulse, filters the direction command and runs a free-running seed.
// Optional macro SNAKE_DIR_QUEUE_EN: buffer up to two direction presses
// between steps instead of a single direction register.
module snake_ctrl #(
    parameter logic [7:0] SIZE_X   = 8'd10,
    parameter logic [7:0] SIZE_Y   = 8'd10,
    parameter int         SBITS    = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
    parameter int         STEP_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_start,
    input  logic             restart,
    output logic             start,
    output logic             step,
    output logic [1:0]       snake_dir,
    output logic [SBITS-1:0] seed,
    output logic             paused
);

    localparam int               CELLS    = int'(SIZE_X) * int'(SIZE_Y);
    localparam int               TBITS    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SBITS-1:0] SEED_MAX = SBITS'(CELLS - 1);
    localparam logic [TBITS-1:0] TICK_MAX = TBITS'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       btn_now;
    logic [4:0]       btn_q;
    logic [4:0]       rise;
    logic [TBITS-1:0] tick_q, tick_d;
    logic             step_q, step_d;
    logic [SBITS-1:0] seed_q, seed_d;
    logic [1:0]       cur_dir_q, cur_dir_d;
    logic             start_rise;
    logic             dir_rise_any;
    logic [1:0]       dir_win;
    logic             dir_ok;
    logic             run_stay;

    // Bit order: 0 up, 1 right, 2 down, 3 left, 4 start.
    assign btn_now = {btn_start, btn_left, btn_down, btn_right, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rise
            assign rise[gi] = btn_now[gi] & ~btn_q[gi];
        end
    endgenerate

    assign start_rise   = rise[4];
    assign dir_rise_any = |rise[3:0];

    // Pick the single highest-priority direction rise: up > right > down > left.
    always_comb begin
        dir_win = 2'd3;
        if (rise[0])      dir_win = 2'd0;
        else if (rise[1]) dir_win = 2'd1;
        else if (rise[2]) dir_win = 2'd2;
    end

    assign dir_ok = dir_rise_any && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; restart always beats a simultaneous start press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (restart || start_rise) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (restart)         state_d = ST_START;
                else if (start_rise) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (restart)         state_d = ST_START;
                else if (start_rise) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Tick, step, seed and committed direction next-state. The counter only
    // advances while staying in RUN, so a pause or restart taken on the
    // terminal count freezes it there and no step escapes outside RUN.
    always_comb begin
        run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);
        tick_d   = tick_q;
        if (state_q == ST_START) begin
            tick_d = '0;
        end else if (run_stay) begin
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        end
        step_d = run_stay && (tick_q == TICK_MAX);
        seed_d = (seed_q == SEED_MAX) ? '0 : seed_q + 1'b1;
        cur_dir_d = cur_dir_q;
        if (state_q == ST_START) cur_dir_d = 2'd1;
        else if (step_q)         cur_dir_d = snake_dir;
    end

    // Button history, tick counter, step pulse, seed and committed direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= '0;
            tick_q    <= '0;
            step_q    <= 1'b0;
            seed_q    <= '0;
            cur_dir_q <= 2'd1;
        end else begin
            btn_q     <= btn_now;
            tick_q    <= tick_d;
            step_q    <= step_d;
            seed_q    <= seed_d;
            cur_dir_q <= cur_dir_d;
        end
    end

`ifdef SNAKE_DIR_QUEUE_EN
    // Two-entry direction FIFO; fifo0 is the head.
    logic [1:0] fifo0_q, fifo0_d;
    logic [1:0] fifo1_q, fifo1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] last_dir;
    logic [1:0] cnt_after_pop;
    logic       pop;
    logic       push;

    // Push/pop decision; an empty FIFO compares against cur_dir.
    always_comb begin
        case (cnt_q)
            2'd1:    last_dir = fifo0_q;
            2'd2:    last_dir = fifo1_q;
            default: last_dir = cur_dir_q;
        endcase
        pop  = step_q && (cnt_q != 2'd0);
        push = dir_ok && (dir_win != last_dir) && ((dir_win ^ last_dir) != 2'd2)
               && ((cnt_q != 2'd2) || pop);
        cnt_after_pop = cnt_q - {1'b0, pop};
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        if (pop) fifo0_d = fifo1_q;
        if (push) begin
            if (cnt_after_pop == 2'd0) fifo0_d = dir_win;
            else                       fifo1_d = dir_win;
        end
        cnt_d = cnt_after_pop + {1'b0, push};
        if (state_q == ST_START) cnt_d = 2'd0;
    end

    // FIFO storage; flushed at reset and on every new game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo0_q <= 2'd1;
            fifo1_q <= 2'd1;
            cnt_q   <= 2'd0;
        end else begin
            fifo0_q <= fifo0_d;
            fifo1_q <= fifo1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign snake_dir = (cnt_q != 2'd0) ? fifo0_q : cur_dir_q;
`else
    logic [1:0] snake_dir_q, snake_dir_d;

    // Single direction register; reversals of the committed direction are dropped.
    always_comb begin
        snake_dir_d = snake_dir_q;
        if (state_q == ST_START) begin
            snake_dir_d = 2'd1;
        end else if (dir_ok && ((dir_win ^ cur_dir_q) != 2'd2)) begin
            snake_dir_d = dir_win;
        end
    end

    // Direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) snake_dir_q <= 2'd1;
        else        snake_dir_q <= snake_dir_d;
    end

    assign snake_dir = snake_dir_q;
`endif

    assign start  = (state_q == ST_START);
    assign paused = (state_q == ST_PAUSE);
    assign step   = step_q;
    assign seed   = seed_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Self-checking bench for snake_ctrl (STEP_DIV=4, 10x10 field).
// Expected step pulses (cycle and carried direction) are queued when the
// stimulus is driven and popped by a monitor when the DUT pulses step.
module tb_snake_ctrl;

    localparam int SB = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic          btn_start = 1'b0, restart = 1'b0;
    logic          start, step, paused;
    logic [1:0]    snake_dir;
    logic [SB-1:0] seed;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    bit sb_on = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } step_t;
    step_t exp_q[$];

    snake_ctrl #(
        .SIZE_X(8'd10),
        .SIZE_Y(8'd10),
        .STEP_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_right(btn_right),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_start(btn_start),
        .restart(restart),
        .start(start),
        .step(step),
        .snake_dir(snake_dir),
        .seed(seed),
        .paused(paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor: every step pulse must match the queue head.
    always @(negedge clk) begin
        step_t e;
        if (rst_n && sb_on) begin
            if (step === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL step_unexpected: step=1 at cycle %0d dir=%0d, required no step", cyc_cnt, snake_dir);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc_cnt || e.dir !== snake_dir) begin
                        n_bad++;
                        $display("FAIL step_sb: step at cycle %0d dir=%0d, required cycle %0d dir=%0d", cyc_cnt, snake_dir, e.cyc, e.dir);
                    end else begin
                        $display("step cycle=%0d dir=%0d", cyc_cnt, snake_dir);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL step_missing: step=%b at cycle %0d, required step with dir=%0d at cycle %0d", step, cyc_cnt, e.dir, e.cyc);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) nxt();
        n_cmp++;
        if ({start, step, paused, snake_dir, seed} !== {3'b000, 2'd1, 7'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: start/step/paused/dir/seed=%b/%b/%b/%0d/%0d, required 0/0/0/1/0", start, step, paused, snake_dir, seed);
        end
        rst_n = 1'b1;
        $display("reset released at cycle %0d", cyc_cnt);
    endtask

    task automatic test_seed();
        logic [SB-1:0] exp_seed;
        for (int k = 0; k < 250; k++) begin
            exp_seed = SB'(k % 100);
            n_cmp++;
            if (seed !== exp_seed) begin
                n_bad++;
                $display("FAIL seed_seq: seed=%0d after %0d cycles, required %0d", seed, k, exp_seed);
            end
            nxt();
        end
        $display("seed sequence checked over 250 cycles");
    endtask

    task automatic test_start_step();
        int a;
        a = cyc_cnt;
        sb_on = 1'b1;
        btn_start = 1'b1;
        exp_q.push_back('{a + 6, 2'd1});
        exp_q.push_back('{a + 10, 2'd1});
        exp_q.push_back('{a + 14, 2'd1});
        nxt();
        btn_start = 1'b0;
        n_cmp++;
        if (start !== 1'b1) begin
            n_bad++;
            $display("FAIL start_pulse: start=%b, required 1", start);
        end
        nxt();
        n_cmp++;
        if ({start, paused} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_one_cycle: start/paused=%b/%b, required 0/0", start, paused);
        end
        while (cyc_cnt < a + 15) nxt();
        sb_on = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_midrun();
        nxt();
        btn_up = 1'b1;
        nxt();
        btn_up = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL dir_before_reset: snake_dir=%0d, required 0", snake_dir);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({start, step, paused, snake_dir, seed} !== {3'b000, 2'd1, 7'd0}) begin
            n_bad++;
            $display("FAIL async_reset: start/step/paused/dir/seed=%b/%b/%b/%0d/%0d, required 0/0/0/1/0", start, step, paused, snake_dir, seed);
        end
        nxt();
        n_cmp++;
        if ({start, step, paused, snake_dir} !== {3'b000, 2'd1}) begin
            n_bad++;
            $display("FAIL reset_no_step: start/step/paused/dir=%b/%b/%b/%0d, required 0/0/0/1", start, step, paused, snake_dir);
        end
        nxt();
        rst_n = 1'b1;
        $display("mid-run reset released at cycle %0d", cyc_cnt);
    endtask

    task automatic test_direction();
        int p;
        p = cyc_cnt;
        sb_on = 1'b1;
        btn_start = 1'b1;
        exp_q.push_back('{p + 6, 2'd0});
        exp_q.push_back('{p + 10, 2'd1});
        nxt();
        btn_start = 1'b0;
        n_cmp++;
        if (start !== 1'b1) begin
            n_bad++;
            $display("FAIL dir_start_pulse: start=%b, required 1", start);
        end
        nxt();
        btn_left = 1'b1;
        nxt();
        btn_left = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd1) begin
            n_bad++;
            $display("FAIL dir_reversal_left: snake_dir=%0d, required 1", snake_dir);
        end
        nxt();
        btn_up = 1'b1;
        nxt();
        btn_up = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL dir_up: snake_dir=%0d, required 0", snake_dir);
        end
        nxt();
        nxt();
        btn_down = 1'b1;
        nxt();
        btn_down = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL dir_commit_reversal: snake_dir=%0d, required 0", snake_dir);
        end
        btn_right = 1'b1;
        nxt();
        btn_right = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd1) begin
            n_bad++;
            $display("FAIL dir_right: snake_dir=%0d, required 1", snake_dir);
        end
        while (cyc_cnt < p + 11) nxt();
        exp_q.delete();
    endtask

    task automatic test_pause();
        int q;
        q = cyc_cnt;
        sb_on = 1'b1;
        restart = 1'b1;
        nxt();
        restart = 1'b0;
        n_cmp++;
        if (start !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_start: start=%b, required 1", start);
        end
        nxt();
        nxt();
        nxt();
        btn_start = 1'b1;
        nxt();
        btn_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (paused !== 1'b1) begin
                n_bad++;
                $display("FAIL paused_hold: paused=%b at pause cycle %0d, required 1", paused, i);
            end
            nxt();
        end
        btn_start = 1'b1;
        exp_q.push_back('{q + 28, 2'd1});
        nxt();
        btn_start = 1'b0;
        n_cmp++;
        if (paused !== 1'b0) begin
            n_bad++;
            $display("FAIL resumed: paused=%b, required 0", paused);
        end
        while (cyc_cnt < q + 29) nxt();
    endtask

    task automatic test_priority_restart();
        int s;
        s = cyc_cnt;
        btn_up = 1'b1;
        btn_down = 1'b1;
        nxt();
        btn_up = 1'b0;
        btn_down = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL prio_up: snake_dir=%0d, required 0", snake_dir);
        end
        restart = 1'b1;
        btn_start = 1'b1;
        exp_q.push_back('{s + 7, 2'd1});
        nxt();
        restart = 1'b0;
        btn_start = 1'b0;
        n_cmp++;
        if ({start, paused} !== 2'b10) begin
            n_bad++;
            $display("FAIL restart_wins_start: start/paused=%b/%b, required 1/0", start, paused);
        end
        nxt();
        n_cmp++;
        if ({start, paused, snake_dir} !== {2'b00, 2'd1}) begin
            n_bad++;
            $display("FAIL restart_wins_run: start/paused/dir=%b/%b/%0d, required 0/0/1", start, paused, snake_dir);
        end
        while (cyc_cnt < s + 8) nxt();
        exp_q.delete();
    endtask

`ifdef SNAKE_DIR_QUEUE_EN
    task automatic test_dir_queue();
        int u;
        u = cyc_cnt;
        sb_on = 1'b1;
        restart = 1'b1;
        exp_q.push_back('{u + 6, 2'd0});
        exp_q.push_back('{u + 10, 2'd3});
        exp_q.push_back('{u + 14, 2'd3});
        nxt();
        restart = 1'b0;
        nxt();
        btn_up = 1'b1;
        nxt();
        btn_up = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL queue_first: snake_dir=%0d, required 0", snake_dir);
        end
        btn_left = 1'b1;
        nxt();
        btn_left = 1'b0;
        n_cmp++;
        if (snake_dir !== 2'd0) begin
            n_bad++;
            $display("FAIL queue_head: snake_dir=%0d, required 0", snake_dir);
        end
        btn_down = 1'b1;
        nxt();
        btn_down = 1'b0;
        nxt();
        nxt();
        n_cmp++;
        if (snake_dir !== 2'd3) begin
            n_bad++;
            $display("FAIL queue_second: snake_dir=%0d, required 3", snake_dir);
        end
        while (cyc_cnt < u + 15) nxt();
        sb_on = 1'b0;
        exp_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seed();
        test_start_step();
        test_reset_midrun();
        test_direction();
        test_pause();
        test_priority_restart();
`ifdef SNAKE_DIR_QUEUE_EN
        test_dir_queue();
`endif
        sb_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_ctrl.md
Name: snake_ctrl

Overview:
- Game controller directly upstream of snake_field; drives its start, step, snake_dir and seed inputs.
- Turns debounced player buttons into a start/pause/restart state machine, a periodic step pulse, a filtered direction command and a free-running apple seed.
- All outputs are registered or decoded from registered state only.

Parameters:
SIZE_X, 8'd10, field width in cells; must match snake_field.
SIZE_Y, 8'd10, field height in cells; must match snake_field.
SBITS, $clog2(SIZE_X*SIZE_Y), seed width.
STEP_DIV, 25_000_000, clock cycles per step pulse; minimum value 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
btn_up  input  1  debounced, synchronous level.
btn_right  input  1  debounced, synchronous level.
btn_down  input  1  debounced, synchronous level.
btn_left  input  1  debounced, synchronous level.
btn_start  input  1  debounced level; a press starts the game or toggles pause.
restart  input  1  synchronous level; forces a new game.
start  output  1  one-cycle pulse; snake_field reinitialises on it.
step  output  1  one-cycle pulse; snake_field advances on it.
snake_dir  output  2  0 up, 1 right, 2 down, 3 left.
seed  output  SBITS  apple seed, range 0..SIZE_X*SIZE_Y-1.
paused  output  1  high while in PAUSE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; start 0, step 0, paused 0, snake_dir 1, cur_dir 1, seed 0, tick counter 0, all button edge registers 0.
- Edge detect: each button has a previous-value register. A rise is btn & ~btn_q and is evaluated in every state.
- FSM states:
  - IDLE: start rise or restart -> START.
  - START: start=1 for exactly one cycle; snake_dir and cur_dir set to 1; tick counter cleared; then -> RUN.
  - RUN: start rise -> PAUSE; restart -> START.
  - PAUSE: start rise -> RUN; restart -> START.
  - When restart and start rise occur in the same cycle, restart wins.
- Tick counter: counts only in RUN, from 0 to STEP_DIV-1, then wraps to 0. step is registered and goes high in the cycle after the counter reaches STEP_DIV-1. The first step occurs exactly STEP_DIV cycles after entering RUN from START. The counter freezes in PAUSE and resumes from the same value. step is never high outside RUN.
- cur_dir is the direction committed at the last step. On each step cycle, cur_dir <= snake_dir.
- Direction input (macro off):
  - Accepted only in RUN or PAUSE.
  - A direction rise whose code XOR cur_dir equals 2 (reversal) is ignored; any other rise loads snake_dir on the next edge.
  - Simultaneous rises resolve by priority up > right > down > left. Only the winner is considered, and it may then be rejected as a reversal.
  - A press in a step cycle affects the following step only; the step uses the snake_dir value present during its own cycle.
- seed: increments every clock in all states and wraps from SIZE_X*SIZE_Y-1 to 0. Arithmetic is SBITS wide; no out-of-range value ever appears.
- paused is decoded from the state register: high exactly while in PAUSE.

Optional Feature:
- Macro SNAKE_DIR_QUEUE_EN.
- Defined: direction presses go into a 2-entry FIFO.
  - A push is rejected if the FIFO is full, if it equals the last queued entry, or if it is the reversal of the last queued entry. When the FIFO is empty, cur_dir stands in as the last queued entry.
  - snake_dir shows the FIFO head while the FIFO is non-empty, otherwise cur_dir.
  - The head pops in each step cycle, after being committed to cur_dir.
  - A push and a pop in the same cycle are both honoured. A full FIFO that pops accepts the push into the freed slot.
  - The FIFO is flushed in START and at reset.
  - Effect: two quick turns between steps are applied on two consecutive steps.
- Undefined: the single-register behaviour above applies and no FIFO logic exists.

Test Plan:
1. STEP_DIV=4. Assert rst_n=0 mid-run with step pending -> all outputs return to reset values immediately, with no step pulse. Release, then press btn_start -> start high for one cycle, then step high every 4th cycle, with the first step 4 cycles after start.
2. RUN, cur_dir=1. Press btn_left -> snake_dir stays 1. Press btn_up -> snake_dir=0. The next step commits cur_dir=0.
3. btn_start rise at counter=2 -> paused=1 and no steps occur for 20 cycles. Second rise -> the next step arrives 2 cycles after resume.
4. Simultaneous btn_up and btn_down rise with cur_dir=1 -> snake_dir=0. In the same cycle as restart, a btn_start rise -> START is taken, not PAUSE.
5. Over 250 cycles with SIZE_X=SIZE_Y=10 -> seed runs 0..99, wraps to 0 at cycle 100, never exceeds 99.
6. (SNAKE_DIR_QUEUE_EN) cur_dir=1. Press up then left before a step -> the next step carries 0 and the step after carries 3. A third press before any step is dropped.
